alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (a, b, select -> OUT, zeroflag) between two requesters.
//  Requesters use a valid/ready handshake to submit operations.
//  A round-robin FSM registers the winner's operands onto the ALU port and captures the result.
//  The result returns to the winner on a valid/ready response channel.
//  Sits between the ALU instance and its clients (e.g. execute stage and branch/address unit).
// PARAMETERS
//  WIDTH  32  operand/result width; matches the ALU datapath
//  SELW   4   ALU select width; passed through undecoded
//  STATW  16  grant-counter width (only with ALU_ARB_STATS_EN)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  reqN_valid   in   1      N=0,1: request pending
//  reqN_ready   out  1      N=0,1: request accepted this cycle
//  reqN_a       in   WIDTH  N=0,1: operand a
//  reqN_b       in   WIDTH  N=0,1: operand b
//  reqN_sel     in   SELW   N=0,1: ALU select
//  respN_valid  out  1      N=0,1: result available
//  respN_ready  in   1      N=0,1: requester takes result
//  respN_result out  WIDTH  N=0,1: captured ALU OUT
//  respN_zero   out  1      N=0,1: captured ALU zeroflag
//  alu_a        out  WIDTH  registered operand to ALU a
//  alu_b        out  WIDTH  registered operand to ALU b
//  alu_sel      out  SELW   registered select to ALU
//  alu_out      in   WIDTH  ALU OUT
//  alu_zero     in   1      ALU zeroflag
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; prio=0 (req0 favoured); all regs and outputs 0; any in-flight op dropped.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - Winner: the only valid requester, or prio when both are valid.
//   - reqW_ready=1 combinationally in that cycle; the handshake is reqW_valid && reqW_ready.
//   - On handshake: latch a/b/sel into alu_*; owner=W; prio=~W; go to EXEC.
//   - If no requester is valid, remain in IDLE.
//  EXEC: the ALU evaluates alu_*; at the clock edge, capture alu_out/alu_zero into the result register; go to RESP.
//  RESP:
//   - respOwner_valid=1 and the result is held stable until respOwner_ready=1.
//   - On the handshake edge, return to IDLE.
//   - The other resp_valid stays 0.
//  reqN_ready=0 outside IDLE. A valid held through EXEC/RESP is arbitrated in the next IDLE.
//  Latency: accept edge to resp_valid=1 is 2 cycles. Minimum issue interval is 3 cycles.
//  respN_ready=1 in the same cycle resp_valid rises completes the handshake in that cycle.
//  alu_* hold their last values outside EXEC; no glitching to 0.
//  sel values are not checked; undefined codes pass through unchanged.
//  Width: result and zero are taken from the ALU as-is; no extension or truncation.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//   - Adds outputs gnt0_cnt and gnt1_cnt [STATW-1:0].
//   - Each counter increments on its requester's accept handshake and saturates at all-ones.
//   - Counters clear on rst_n.
//  ALU_ARB_STATS_EN undefined: the counters and their ports are absent; all other behaviour is identical.
// TESTING
//  The bench ALU stub implements sel=0 as a+b and sel=1 as a-b; zero = (out==0).
//  1 Single: req0 a=1 b=1 sel=0 -> ready0 at cycle t, resp0_valid at t+2, result=2, zero=0.
//  2 Zero flag: req1 a=1 b=1 sel=1 -> resp1_result=0, resp1_zero=1, resp0_valid stays 0.
//  3 Contention: both valid from reset, 4 ops each -> grants alternate 0,1,0,1... and all results match the stub.
//  4 Backpressure: resp0_ready=0 for 5 cycles -> resp0_valid/result stable, no new ready; accept next op 1 cycle after handshake.
//  5 Reset mid-op: assert rst_n=0 in EXEC -> all outputs 0 at once, resp never issued, prio=0 after release.
//  6 STATS_EN: 3 req0 + 2 req1 ops -> gnt0_cnt=3, gnt1_cnt=2; force count to max, then grant -> stays all-ones.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional grant counters are compiled in with ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SELW  = 4
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int unsigned STATW = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SELW-1:0]  req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SELW-1:0]  req1_sel,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STATW-1:0] gnt0_cnt,
    output logic [STATW-1:0] gnt1_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             prio;
    logic             owner;
    logic             win;
    logic             acc;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;

    // Winner selection, handshakes and next state
    always_comb begin
        state_nxt   = state;
        win         = prio;
        acc         = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        if (req0_valid && !req1_valid) begin
            win = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            win = 1'b1;
        end
        case (state)
            S_IDLE: begin
                req0_ready = req0_valid && !win;
                req1_ready = req1_valid && win;
                acc        = req0_valid || req1_valid;
                if (acc) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                if (owner ? resp1_ready : resp0_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, arbitration priority and ALU operand/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                owner   <= win;
                prio    <= !win;
                alu_a   <= win ? req1_a   : req0_a;
                alu_b   <= win ? req1_b   : req0_b;
                alu_sel <= win ? req1_sel : req0_sel;
            end
            if (state == S_EXEC) begin
                res_q  <= alu_out;
                zero_q <= alu_zero;
            end
        end
    end

    assign resp0_result = res_q;
    assign resp1_result = res_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;

`ifdef ALU_ARB_STATS_EN
    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (acc) begin
            if (!win && (gnt0_cnt != '1)) begin
                gnt0_cnt <= gnt0_cnt + STATW'(1);
            end
            if (win && (gnt1_cnt != '1)) begin
                gnt1_cnt <= gnt1_cnt + STATW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors plus a transaction-level reference model.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic        resp0_valid, resp1_valid;
    logic        rr0 = 1'b1, rr1 = 1'b1;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_zero, resp1_zero;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_zero;
`ifdef ALU_ARB_STATS_EN
    logic [1:0]  gnt0_cnt, gnt1_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_out == 32'd0);

`ifdef ALU_ARB_STATS_EN
    alu_share_arbiter #(.WIDTH(32), .SELW(4), .STATW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp0_valid(resp0_valid), .resp0_ready(rr0), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(rr1), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
    );
`else
    alu_share_arbiter #(.WIDTH(32), .SELW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .resp0_valid(resp0_valid), .resp0_ready(rr0), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(rr1), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero)
    );
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one outstanding op, round-robin on contention, response two cycles after accept
    bit          busy = 0;
    bit          mprio = 0;
    bit          mown = 0;
    int          macc = 0;
    logic [31:0] ma = '0, mb = '0, mres = '0;
    logic [3:0]  msel = '0;
    int          gq[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy = 0; mprio = 0; ma = '0; mb = '0; msel = '0;
        end else begin
            bit b, ev0, ev1, ew;
            b   = busy;
            chk("alu_ports", {alu_sel, alu_a, alu_b}, {msel, ma, mb});
            ev0 = b && !mown && (cyc >= macc + 2);
            ev1 = b &&  mown && (cyc >= macc + 2);
            chk("resp_valid", {resp1_valid, resp0_valid}, {ev1, ev0});
            if (ev0) chk("resp0_data", {resp0_zero, resp0_result}, {mres == 0, mres});
            if (ev1) chk("resp1_data", {resp1_zero, resp1_result}, {mres == 0, mres});
            if ((ev0 && rr0) || (ev1 && rr1)) busy = 0;
            if (!b && (req0_valid || req1_valid)) begin
                ew = (req0_valid && req1_valid) ? mprio : req1_valid;
                chk("grant", {req1_ready, req0_ready}, ew ? 2'b10 : 2'b01);
                busy = 1; mown = ew; macc = cyc; mprio = !ew; gq.push_back(int'(ew));
                ma   = ew ? req1_a : req0_a;
                mb   = ew ? req1_b : req0_b;
                msel = ew ? req1_sel : req0_sel;
                mres = alu_f(ma, mb, msel);
            end else begin
                chk("no_ready", {req1_ready, req0_ready}, 2'b00);
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        if (p == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = s; end
        else        begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = s; end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s, output int t);
        int n = 0;
        logic rdy;
        @(posedge clk); #1;
        drive(p, 1'b1, a, b, s);
        do begin
            @(negedge clk); n++;
            rdy = (p == 0) ? req0_ready : req1_ready;
        end while (!rdy && n < 100);
        t = cyc;
        chk("accept_seen", rdy, 1'b1);
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int p, output int t, output logic [31:0] r, output logic z, output bit other);
        int n = 0;
        logic v;
        other = 0;
        do begin
            @(negedge clk); n++;
            v = (p == 0) ? resp0_valid : resp1_valid;
            if ((p == 0) ? resp1_valid : resp0_valid) other = 1;
        end while (!v && n < 50);
        t = cyc;
        r = (p == 0) ? resp0_result : resp1_result;
        z = (p == 0) ? resp0_zero : resp1_zero;
        chk("resp_seen", v, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0, t1, tr, n;
        logic [31:0] r;
        logic z;
        bit oth;
        logic [7:0] go;

        // Reset state
        #2;
        chk("reset_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero, alu_sel},
            {6'b0, 4'h0});
        chk("reset_datapath", {alu_a, alu_b, resp0_result}, 96'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single op, latency 2
        issue(0, 32'd1, 32'd1, 4'd0, t0);
        wait_resp(0, tr, r, z, oth);
        chk("t1_latency", 64'(tr - t0), 64'd2);
        chk("t1_result", {z, r}, {1'b0, 32'd2});

        // 2: zero flag on requester 1
        issue(1, 32'd1, 32'd1, 4'd1, t0);
        wait_resp(1, tr, r, z, oth);
        chk("t2_result", {z, r}, {1'b1, 32'd0});
        chk("t2_resp0_quiet", oth, 1'b0);
        repeat (2) @(negedge clk);

        // 3: contention from reset, grants must alternate starting at 0
        do_reset();
        gq.delete();
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 32'(i + 10), 32'd3, 4'(i & 1), t0); end
            begin for (int i = 0; i < 4; i++) issue(1, 32'(100 + i), 32'(i), (i == 3) ? 4'hf : 4'(i & 1), t1); end
        join
        repeat (6) @(negedge clk);
        chk("t3_grant_count", 64'(gq.size()), 64'd8);
        go = '0;
        for (int i = 0; i < 8 && i < gq.size(); i++) go[i] = gq[i][0];
        chk("t3_grant_order", go, 8'b1010_1010);

        // 4: response backpressure with a competing request pending
        rr0 = 1'b0;
        issue(0, 32'd5, 32'd3, 4'd1, t0);
        drive(1, 1'b1, 32'd7, 32'd7, 4'd1);
        wait_resp(0, tr, r, z, oth);
        chk("t4_result", {z, r}, {1'b0, 32'd2});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold", {resp0_valid, req1_ready, resp0_zero, resp0_result}, {3'b100, 32'd2});
        end
        @(posedge clk); #1 rr0 = 1'b1;
        @(negedge clk);
        chk("t4_handshake", {resp0_valid, req1_ready}, 2'b10);
        @(negedge clk);
        chk("t4_next_accept", req1_ready, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_resp(1, tr, r, z, oth);
        chk("t4_r1_result", {z, r}, {1'b1, 32'd0});
        repeat (2) @(negedge clk);

        // 5: reset during EXEC drops the op and restores prio 0
        @(posedge clk); #1 drive(0, 1'b1, 32'd9, 32'd9, 4'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
        chk("t5_accept", req0_ready, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, alu_sel}, 9'd0);
        chk("t5_rst_datapath", {alu_a, alu_b, resp0_result}, 96'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_resp", {resp0_valid, resp1_valid}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;
        gq.delete();
        fork
            issue(0, 32'd4, 32'd4, 4'd1, t0);
            issue(1, 32'd6, 32'd2, 4'd0, t1);
        join
        repeat (6) @(negedge clk);
        chk("t5_first_grant", 64'(gq.size() > 0 ? gq[0] : 9), 64'd0);
        chk("t5_second_grant", 64'(gq.size() > 1 ? gq[1] : 9), 64'd1);

`ifdef ALU_ARB_STATS_EN
        // 6: grant counters, 2-bit so saturation is reachable
        do_reset();
        for (int i = 0; i < 3; i++) issue(0, 32'(i), 32'd1, 4'd0, t0);
        for (int i = 0; i < 2; i++) issue(1, 32'(i), 32'd1, 4'd1, t1);
        repeat (4) @(negedge clk);
        chk("t6_counts", {gnt0_cnt, gnt1_cnt}, {2'd3, 2'd2});
        issue(0, 32'd1, 32'd2, 4'd0, t0);
        for (int i = 0; i < 2; i++) issue(1, 32'd3, 32'd1, 4'd1, t1);
        repeat (4) @(negedge clk);
        chk("t6_saturate", {gnt0_cnt, gnt1_cnt}, {2'd3, 2'd3});
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
